// File: rtl/acq_pkg.sv
// Shared definitions for the acquisition channel switch.
//   acq_state_t : switch controller states (RUN forwards samples, GUARD discards them)
//   clog2_min1  : ceil(log2(n)) clamped to at least 1, for index/counter widths
//   ADC_W_DEF / DATA_W_DEF : default sample and result word widths
package acq_pkg;

    localparam int unsigned ADC_W_DEF  = 12;
    localparam int unsigned DATA_W_DEF = 16;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_GUARD = 1'b1
    } acq_state_t;

    // Width needed to index n items; never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 32'd2) ? 32'd1 : 32'($clog2(n));
    endfunction

endpackage

// File: rtl/acq_guard_cnt.sv
// Settle-guard down-counter.
//   clk, rst : clock and synchronous active-high reset
//   load     : reload the counter with load_val (wins over dec)
//   load_val : reload value
//   dec      : decrement strobe, ignored once the counter is at zero
//   cnt      : current count (registered)
//   zero_c   : combinational flag, cnt == 0
module acq_guard_cnt #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         zero_c
);

    assign zero_c = (cnt == '0);

    // Reload has priority so a new switch always restarts the full guard.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && !zero_c) begin
            cnt <= cnt - W'(1);
        end
    end

endmodule

// File: rtl/acq_ch_switch.sv
// Acquisition channel switch: routes the shared ADC sample stream to one of
// NUM_CH channels and returns that channel's result word and tick. A channel
// change discards GUARD_SMP samples while the new channel settles.
//   clk, rst      : clock and synchronous active-high reset
//   sel_req       : requested channel index, applied on sel_load pulse
//   adc_data/vld  : ADC sample and its valid strobe
//   ch_data       : flattened per-channel result words, channel k at [k*DATA_W +: DATA_W]
//   ch_tick       : per-channel acquisition tick pulses
//   ch_adc_data   : registered sample bus shared by all channels
//   ch_adc_vld    : one-hot sample valid towards the selected channel
//   dataout       : selected channel result word
//   acq_tick      : selected channel tick
//   cur_sel       : active channel index
//   switching     : high while samples are being discarded after a switch
//   sel_err       : one-cycle pulse when an out-of-range sel_req is rejected
//   smp_cnt       : samples forwarded since the last switch, saturating
module acq_ch_switch
    import acq_pkg::*;
#(
    parameter  int unsigned NUM_CH     = 4,
    parameter  int unsigned ADC_W      = ADC_W_DEF,
    parameter  int unsigned DATA_W     = DATA_W_DEF,
    parameter  int unsigned GUARD_SMP  = 8,
    parameter  int unsigned CNT_W      = 16,
    parameter  int unsigned DEFAULT_CH = 0,
    localparam int unsigned CH_W       = clog2_min1(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CH_W-1:0]          sel_req,
    input  logic                     sel_load,
    input  logic [ADC_W-1:0]         adc_data,
    input  logic                     adc_vld,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic [NUM_CH-1:0]        ch_tick,
    output logic [ADC_W-1:0]         ch_adc_data,
    output logic [NUM_CH-1:0]        ch_adc_vld,
    output logic [DATA_W-1:0]        dataout,
    output logic                     acq_tick,
    output logic [CH_W-1:0]          cur_sel,
    output logic                     switching,
    output logic                     sel_err,
    output logic [CNT_W-1:0]         smp_cnt
);

    localparam int unsigned GW = clog2_min1(GUARD_SMP + 1);

    acq_state_t          state;
    logic [NUM_CH-1:0]   onehot_c;
    logic [DATA_W-1:0]   sel_data_c;
    logic                sel_tick_c;
    logic                req_illegal_c;
    logic                req_change_c;
    logic                guard_load_c;
    logic                guard_dec_c;
    logic                guard_last_c;
    logic                guard_zero_c;
    logic [GW-1:0]       guard_cnt;

    // Decode of the current selection: one-hot valid, result word and tick.
    always_comb begin
        onehot_c   = '0;
        sel_data_c = '0;
        sel_tick_c = 1'b0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (cur_sel == CH_W'(k)) begin
                onehot_c[k] = 1'b1;
                sel_data_c  = ch_data[k*DATA_W +: DATA_W];
                sel_tick_c  = ch_tick[k];
            end
        end
    end

    // Request qualification; only a legal, different channel starts a switch.
    assign req_illegal_c = (32'(sel_req) >= NUM_CH);
    assign req_change_c  = (sel_req != cur_sel);
    assign guard_load_c  = sel_load && !req_illegal_c && req_change_c && (GUARD_SMP != 0);
    assign guard_dec_c   = (state == ST_GUARD) && adc_vld;
    assign guard_last_c  = (guard_cnt == GW'(1));

    acq_guard_cnt #(
        .W (GW)
    ) u_guard_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (guard_load_c),
        .load_val (GW'(GUARD_SMP)),
        .dec      (guard_dec_c),
        .cnt      (guard_cnt),
        .zero_c   (guard_zero_c)
    );

    // Controller and registered datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_RUN;
            cur_sel     <= CH_W'(DEFAULT_CH);
            ch_adc_data <= '0;
            ch_adc_vld  <= '0;
            dataout     <= '0;
            acq_tick    <= 1'b0;
            switching   <= 1'b0;
            sel_err     <= 1'b0;
            smp_cnt     <= '0;
        end else begin
            ch_adc_vld <= '0;
            acq_tick   <= 1'b0;
            sel_err    <= sel_load && req_illegal_c;

            case (state)
                ST_RUN: begin
                    // A sample arriving with a switch request still uses the old channel.
                    if (adc_vld) begin
                        ch_adc_data <= adc_data;
                        ch_adc_vld  <= onehot_c;
                        if (smp_cnt != '1) begin
                            smp_cnt <= smp_cnt + CNT_W'(1);
                        end
                    end
                    dataout  <= sel_data_c;
                    acq_tick <= sel_tick_c;
                    if (sel_load && !req_illegal_c && req_change_c) begin
                        cur_sel <= sel_req;
                        smp_cnt <= '0;
                        if (GUARD_SMP != 0) begin
                            state     <= ST_GUARD;
                            switching <= 1'b1;
                        end
                    end
                end

                ST_GUARD: begin
                    // A newer legal request restarts the guard; the counter reloads itself.
                    if (sel_load && !req_illegal_c && req_change_c) begin
                        cur_sel <= sel_req;
                    end else if (guard_zero_c || (adc_vld && guard_last_c)) begin
                        state     <= ST_RUN;
                        switching <= 1'b0;
                    end
                end

                default: begin
                    state     <= ST_RUN;
                    switching <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_acq_ch_switch.sv
// Self-checking bench for acq_ch_switch.
// Instance a: NUM_CH=4, GUARD_SMP=8. Instance b: NUM_CH=5, GUARD_SMP=0 (illegal
// indices representable, zero-length guard).
module tb_acq_ch_switch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [2:0]  sel_req;
    logic        sel_load_a;
    logic        sel_load_b;
    logic [11:0] adc_data;
    logic        adc_vld;
    logic [79:0] ch_data;
    logic [4:0]  ch_tick;

    logic [11:0] a_adc_data;
    logic [3:0]  a_adc_vld;
    logic [15:0] a_dataout;
    logic        a_tick;
    logic [1:0]  a_sel;
    logic        a_sw;
    logic        a_err;
    logic [15:0] a_cnt;

    logic [11:0] b_adc_data;
    logic [4:0]  b_adc_vld;
    logic [15:0] b_dataout;
    logic        b_tick;
    logic [2:0]  b_sel;
    logic        b_sw;
    logic        b_err;
    logic [15:0] b_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0]  ch;
        logic [11:0] data;
    } exp_t;

    exp_t sb[$];

    acq_ch_switch #(
        .NUM_CH (4), .ADC_W (12), .DATA_W (16), .GUARD_SMP (8), .CNT_W (16), .DEFAULT_CH (0)
    ) dut_a (
        .clk         (clk),
        .rst         (rst),
        .sel_req     (sel_req[1:0]),
        .sel_load    (sel_load_a),
        .adc_data    (adc_data),
        .adc_vld     (adc_vld),
        .ch_data     (ch_data[63:0]),
        .ch_tick     (ch_tick[3:0]),
        .ch_adc_data (a_adc_data),
        .ch_adc_vld  (a_adc_vld),
        .dataout     (a_dataout),
        .acq_tick    (a_tick),
        .cur_sel     (a_sel),
        .switching   (a_sw),
        .sel_err     (a_err),
        .smp_cnt     (a_cnt)
    );

    acq_ch_switch #(
        .NUM_CH (5), .ADC_W (12), .DATA_W (16), .GUARD_SMP (0), .CNT_W (16), .DEFAULT_CH (0)
    ) dut_b (
        .clk         (clk),
        .rst         (rst),
        .sel_req     (sel_req),
        .sel_load    (sel_load_b),
        .adc_data    (adc_data),
        .adc_vld     (adc_vld),
        .ch_data     (ch_data),
        .ch_tick     (ch_tick),
        .ch_adc_data (b_adc_data),
        .ch_adc_vld  (b_adc_vld),
        .dataout     (b_dataout),
        .acq_tick    (b_tick),
        .cur_sel     (b_sel),
        .switching   (b_sw),
        .sel_err     (b_err),
        .smp_cnt     (b_cnt)
    );

    // Scoreboard consumer: every sample forwarded by instance a must match the queue head.
    always @(negedge clk) begin
        if (a_adc_vld !== 4'b0000) begin
            exp_t e;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sample_unexpected: ch_adc_vld=%b data=%h, required no sample", a_adc_vld, a_adc_data);
            end else begin
                e = sb.pop_front();
                if (a_adc_vld !== (4'b0001 << e.ch) || a_adc_data !== e.data) begin
                    errors++;
                    $display("FAIL sample_route: ch_adc_vld=%b data=%h, required ch %0d data %h",
                             a_adc_vld, a_adc_data, e.ch, e.data);
                end
            end
        end
    end

    // Apply one cycle of stimulus at a negedge and return at the next negedge.
    task automatic drive(input logic vld, input logic [11:0] d, input logic ld_a, input logic ld_b,
                         input logic [2:0] req, input logic fwd, input logic [3:0] ch);
        exp_t e;
        adc_vld    = vld;
        adc_data   = d;
        sel_load_a = ld_a;
        sel_load_b = ld_b;
        sel_req    = req;
        if (vld && fwd) begin
            e.ch   = ch;
            e.data = d;
            sb.push_back(e);
        end
        @(negedge clk);
        adc_vld    = 1'b0;
        sel_load_a = 1'b0;
        sel_load_b = 1'b0;
    endtask

    task automatic smp(input logic [11:0] d, input logic fwd, input logic [3:0] ch);
        drive(1'b1, d, 1'b0, 1'b0, 3'd0, fwd, ch);
    endtask

    task automatic idle();
        drive(1'b0, 12'h000, 1'b0, 1'b0, 3'd0, 1'b0, 4'd0);
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        ch_tick = 5'b11111;
        drive(1'b1, 12'hFFF, 1'b1, 1'b1, 3'd2, 1'b0, 4'd0);
        drive(1'b1, 12'hABC, 1'b0, 1'b0, 3'd0, 1'b0, 4'd0);
        ch_tick = 5'b00000;
        checks++;
        if (a_sel !== 2'd0 || a_sw !== 1'b0 || a_err !== 1'b0 || a_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_ctrl: sel=%0d sw=%b err=%b cnt=%0d, required 0 0 0 0", a_sel, a_sw, a_err, a_cnt);
        end
        checks++;
        if (a_adc_vld !== 4'b0 || a_adc_data !== 12'h0 || a_dataout !== 16'h0 || a_tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: vld=%b data=%h dout=%h tick=%b, required all 0",
                     a_adc_vld, a_adc_data, a_dataout, a_tick);
        end
        checks++;
        if (b_sel !== 3'd0 || b_cnt !== 16'd0 || b_adc_vld !== 5'b0) begin
            errors++;
            $display("FAIL reset_b: sel=%0d cnt=%0d vld=%b, required 0 0 0", b_sel, b_cnt, b_adc_vld);
        end
        rst = 1'b0;
    endtask

    task automatic test_run_basic();
        for (int i = 1; i <= 3; i++) begin
            smp(12'h123, 1'b1, 4'd0);
            checks++;
            if (a_cnt !== 16'(i) || a_adc_data !== 12'h123) begin
                errors++;
                $display("FAIL run_count: smp_cnt=%0d data=%h, required %0d 123", a_cnt, a_adc_data, i);
            end
        end
        idle();
        checks++;
        if (a_adc_vld !== 4'b0000 || a_adc_data !== 12'h123) begin
            errors++;
            $display("FAIL run_idle: vld=%b data=%h, required 0000 123", a_adc_vld, a_adc_data);
        end
    endtask

    task automatic test_switch_guard();
        drive(1'b0, 12'h000, 1'b1, 1'b0, 3'd2, 1'b0, 4'd0);
        checks++;
        if (a_sel !== 2'd2 || a_sw !== 1'b1 || a_cnt !== 16'd0) begin
            errors++;
            $display("FAIL switch_enter: sel=%0d sw=%b cnt=%0d, required 2 1 0", a_sel, a_sw, a_cnt);
        end
        for (int i = 1; i <= 10; i++) begin
            smp(12'(i), (i > 8) ? 1'b1 : 1'b0, 4'd2);
            if (i == 1) begin
                checks++;
                if (a_adc_data !== 12'h123) begin
                    errors++;
                    $display("FAIL guard_hold: ch_adc_data=%h, required 123", a_adc_data);
                end
            end
            if (i == 7 || i == 8) begin
                checks++;
                if (a_sw !== ((i == 7) ? 1'b1 : 1'b0)) begin
                    errors++;
                    $display("FAIL guard_switching: after sample %0d switching=%b, required %b", i, a_sw, (i == 7));
                end
            end
        end
        checks++;
        if (a_cnt !== 16'd2) begin
            errors++;
            $display("FAIL guard_count: smp_cnt=%0d, required 2", a_cnt);
        end
    endtask

    task automatic test_tick_data();
        ch_data          = '0;
        ch_data[15:0]    = 16'h1111;
        ch_data[47:32]   = 16'hBEEF;
        ch_tick          = 5'b00100;
        idle();
        ch_tick          = 5'b01011;
        checks++;
        if (a_tick !== 1'b1 || a_dataout !== 16'hBEEF) begin
            errors++;
            $display("FAIL tick_sel: tick=%b dout=%h, required 1 BEEF", a_tick, a_dataout);
        end
        idle();
        ch_tick = 5'b00000;
        checks++;
        if (a_tick !== 1'b0) begin
            errors++;
            $display("FAIL tick_unsel: tick=%b, required 0", a_tick);
        end
        drive(1'b0, 12'h000, 1'b1, 1'b0, 3'd3, 1'b0, 4'd0);
        ch_data[63:48] = 16'hCAFE;
        ch_tick        = 5'b01000;
        idle();
        ch_tick        = 5'b00000;
        checks++;
        if (a_tick !== 1'b0 || a_dataout !== 16'hBEEF || a_sw !== 1'b1) begin
            errors++;
            $display("FAIL tick_guard: tick=%b dout=%h sw=%b, required 0 BEEF 1", a_tick, a_dataout, a_sw);
        end
        for (int i = 0; i < 8; i++) smp(12'h0C0 + 12'(i), 1'b0, 4'd3);
        idle();
        checks++;
        if (a_sw !== 1'b0 || a_dataout !== 16'hCAFE || a_sel !== 2'd3) begin
            errors++;
            $display("FAIL tick_newch: sw=%b dout=%h sel=%0d, required 0 CAFE 3", a_sw, a_dataout, a_sel);
        end
    endtask

    task automatic test_sel_err();
        drive(1'b0, 12'h000, 1'b0, 1'b1, 3'd5, 1'b0, 4'd0);
        checks++;
        if (b_err !== 1'b1 || b_sel !== 3'd0 || b_sw !== 1'b0) begin
            errors++;
            $display("FAIL err_pulse: err=%b sel=%0d sw=%b, required 1 0 0", b_err, b_sel, b_sw);
        end
        idle();
        checks++;
        if (b_err !== 1'b0) begin
            errors++;
            $display("FAIL err_width: err=%b, required 0", b_err);
        end
        drive(1'b0, 12'h000, 1'b0, 1'b1, 3'd7, 1'b0, 4'd0);
        checks++;
        if (b_err !== 1'b1 || b_sel !== 3'd0) begin
            errors++;
            $display("FAIL err_seven: err=%b sel=%0d, required 1 0", b_err, b_sel);
        end
        drive(1'b1, 12'h3A3, 1'b1, 1'b0, 3'd3, 1'b1, 4'd3);
        checks++;
        if (a_err !== 1'b0 || a_sw !== 1'b0 || a_cnt !== 16'd1 || a_sel !== 2'd3) begin
            errors++;
            $display("FAIL same_sel: err=%b sw=%b cnt=%0d sel=%0d, required 0 0 1 3", a_err, a_sw, a_cnt, a_sel);
        end
    endtask

    task automatic test_guard_reload();
        drive(1'b0, 12'h000, 1'b1, 1'b0, 3'd0, 1'b0, 4'd0);
        for (int i = 0; i < 3; i++) smp(12'h050 + 12'(i), 1'b0, 4'd0);
        drive(1'b0, 12'h000, 1'b1, 1'b0, 3'd1, 1'b0, 4'd0);
        checks++;
        if (a_sel !== 2'd1 || a_sw !== 1'b1) begin
            errors++;
            $display("FAIL reload_sel: sel=%0d sw=%b, required 1 1", a_sel, a_sw);
        end
        for (int i = 1; i <= 8; i++) begin
            smp(12'h060 + 12'(i), 1'b0, 4'd1);
            if (i >= 7) begin
                checks++;
                if (a_sw !== ((i == 7) ? 1'b1 : 1'b0)) begin
                    errors++;
                    $display("FAIL reload_guard: after sample %0d switching=%b, required %b", i, a_sw, (i == 7));
                end
            end
        end
        smp(12'h0A5, 1'b1, 4'd1);
        drive(1'b1, 12'h0B6, 1'b1, 1'b0, 3'd2, 1'b1, 4'd1);
        checks++;
        if (a_sel !== 2'd2 || a_sw !== 1'b1 || a_cnt !== 16'd0) begin
            errors++;
            $display("FAIL simul_switch: sel=%0d sw=%b cnt=%0d, required 2 1 0", a_sel, a_sw, a_cnt);
        end
    endtask

    task automatic test_reset_guard_zero();
        smp(12'h0D1, 1'b0, 4'd2);
        smp(12'h0D2, 1'b0, 4'd2);
        rst     = 1'b1;
        ch_tick = 5'b11111;
        smp(12'h7FF, 1'b0, 4'd0);
        rst     = 1'b0;
        ch_tick = 5'b00000;
        checks++;
        if (a_sel !== 2'd0 || a_sw !== 1'b0 || a_cnt !== 16'd0 || a_adc_vld !== 4'b0 ||
            a_adc_data !== 12'h0 || a_dataout !== 16'h0 || a_tick !== 1'b0 || a_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_guard: sel=%0d sw=%b cnt=%0d vld=%b data=%h dout=%h tick=%b, required all 0",
                     a_sel, a_sw, a_cnt, a_adc_vld, a_adc_data, a_dataout, a_tick);
        end
        drive(1'b0, 12'h000, 1'b0, 1'b1, 3'd4, 1'b0, 4'd0);
        checks++;
        if (b_sel !== 3'd4 || b_sw !== 1'b0 || b_err !== 1'b0 || b_cnt !== 16'd0) begin
            errors++;
            $display("FAIL zero_guard_sw: sel=%0d sw=%b err=%b cnt=%0d, required 4 0 0 0", b_sel, b_sw, b_err, b_cnt);
        end
        smp(12'h321, 1'b1, 4'd0);
        checks++;
        if (b_adc_vld !== 5'b10000 || b_adc_data !== 12'h321 || b_cnt !== 16'd1) begin
            errors++;
            $display("FAIL zero_guard_fwd: vld=%b data=%h cnt=%0d, required 10000 321 1", b_adc_vld, b_adc_data, b_cnt);
        end
    endtask

    initial begin
        rst        = 1'b1;
        sel_req    = 3'd0;
        sel_load_a = 1'b0;
        sel_load_b = 1'b0;
        adc_data   = 12'h000;
        adc_vld    = 1'b0;
        ch_data    = '0;
        ch_tick    = '0;
        @(negedge clk);
        test_reset();
        test_run_basic();
        test_switch_guard();
        test_tick_data();
        test_sel_err();
        test_guard_reload();
        test_reset_guard_zero();
        idle();
        idle();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d expected samples never forwarded, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
